// File: rtl/spi_frame_pkg.sv
// rtl/spi_frame_pkg.sv - shared widths and FSM state type for the SPI frame slave
package spi_frame_pkg;

    localparam int FRAME_W  = 128;
    localparam int PKT_W    = 32;
    localparam int BITCNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_frame_slave_pin_sync.sv
// rtl/spi_frame_slave_pin_sync.sv - multi-flop synchroniser for one SPI pin with edge strobes
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   i_pin        raw asynchronous pin
//   o_level      synchronised level (SYNC_STAGES clk after the pin)
//   o_rise       one-cycle strobe, SYNC_STAGES+1 clk after a raw rising edge
//   o_fall       one-cycle strobe, SYNC_STAGES+1 clk after a raw falling edge
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];

    // Strobes are registered so that acting on them lands a consumer's
    // update exactly SYNC_STAGES+2 clk after the raw pin edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_dly  <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_dly  <= w_level;
            r_rise <= w_level & ~r_dly;
            r_fall <= ~w_level & r_dly;
        end
    end

    assign o_level = w_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/spi_frame_slave.sv
// rtl/spi_frame_slave.sv - oversampled SPI mode-0 slave: 128-bit frames out on MISO, 32-bit packets in from MOSI
//
// Optional build macro: SPI_MISO_TRISTATE_EN (MISO released to Z while deselected).
//
// Ports:
//   clk, rst     system clock (>= 10x SCK), asynchronous active-high reset
//   SCK, MOSI    raw SPI clock and data in (mode 0, MSB first)
//   CS_N         raw chip select, active low
//   MISO         SPI data out, MSB first
//   TxFrame      frame to transmit, held stable by the framer
//   TxGetNext    toggles on every frame load (request for the next frame)
//   RxPacket     last complete 32-bit packet received
//   PktComplete  toggles on every completed packet
//   CS           synchronised chip select, 1 = deselected
module spi_frame_slave
    import spi_frame_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               SCK,
    input  logic               MOSI,
    input  logic               CS_N,
    output logic               MISO,
    input  logic [FRAME_W-1:0] TxFrame,
    output logic               TxGetNext,
    output logic [PKT_W-1:0]   RxPacket,
    output logic               PktComplete,
    output logic               CS
);

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_sck_level;
    logic w_mosi;
    logic w_cs;
    logic [3:0] w_unused_edges;

    logic w_mosi_rise;
    logic w_mosi_fall;
    logic w_cs_rise;
    logic w_cs_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (SCK),
        .o_level (w_sck_level),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (MOSI),
        .o_level (w_mosi),
        .o_rise  (w_mosi_rise),
        .o_fall  (w_mosi_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (CS_N),
        .o_level (w_cs),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    // Only SCK needs edge strobes; CS is acted on by level so the LOAD
    // cycle lands one clk earlier than a strobe would allow.
    assign w_unused_edges = {w_mosi_rise, w_mosi_fall, w_cs_rise, w_cs_fall ^ w_sck_level};

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_load;

    logic [FRAME_W-1:0]    r_tx_sr;
    logic [PKT_W-1:0]      r_rx_sr;
    logic [PKT_W-1:0]      r_rx_packet;
    logic [BITCNT_W-1:0]   r_bitcnt;
    logic                  r_wrapped;
    logic                  r_miso;
    logic                  r_tx_get_next;
    logic                  r_pkt_complete;

    logic                  w_shift_active;
    logic                  w_rx_take;
    logic                  w_tx_step;
    logic                  w_tx_reload;
    logic                  w_pkt_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Deselect wins over everything, including a same-cycle SCK strobe.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_cs) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_cs) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_load       = 1'b1;
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_cs) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_shift_active = (r_state == ST_SHIFT) && !w_cs;
    assign w_rx_take      = w_shift_active && w_sck_rise;
    assign w_pkt_done     = w_rx_take && (r_bitcnt[4:0] == 5'd31);
    // A fall with bitcnt==0 is either the first fall of a select (ignored)
    // or the fall that closes a full frame (reload the next one).
    assign w_tx_step      = w_shift_active && w_sck_fall && (r_bitcnt != '0);
    assign w_tx_reload    = w_shift_active && w_sck_fall && (r_bitcnt == '0) && r_wrapped;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_sr        <= '0;
            r_rx_sr        <= '0;
            r_rx_packet    <= '0;
            r_bitcnt       <= '0;
            r_wrapped      <= 1'b0;
            r_miso         <= 1'b0;
            r_tx_get_next  <= 1'b0;
            r_pkt_complete <= 1'b0;
        end else if (w_cs) begin
            // Deselected: drop partial rx/tx state, keep the last packet.
            r_rx_sr   <= '0;
            r_bitcnt  <= '0;
            r_wrapped <= 1'b0;
            r_miso    <= 1'b0;
        end else if (w_load) begin
            r_tx_sr       <= TxFrame;
            r_miso        <= TxFrame[FRAME_W-1];
            r_tx_get_next <= ~r_tx_get_next;
            r_bitcnt      <= '0;
            r_wrapped     <= 1'b0;
        end else begin
            if (w_rx_take) begin
                r_rx_sr  <= {r_rx_sr[PKT_W-2:0], w_mosi};
                r_bitcnt <= r_bitcnt + BITCNT_W'(1);
                if (r_bitcnt == BITCNT_W'(FRAME_W - 1)) begin
                    r_wrapped <= 1'b1;
                end
                if (w_pkt_done) begin
                    r_rx_packet    <= {r_rx_sr[PKT_W-2:0], w_mosi};
                    r_pkt_complete <= ~r_pkt_complete;
                end
            end
            if (w_tx_step) begin
                r_tx_sr <= {r_tx_sr[FRAME_W-2:0], 1'b0};
                r_miso  <= r_tx_sr[FRAME_W-2];
            end
            if (w_tx_reload) begin
                r_tx_sr       <= TxFrame;
                r_miso        <= TxFrame[FRAME_W-1];
                r_tx_get_next <= ~r_tx_get_next;
                r_wrapped     <= 1'b0;
            end
        end
    end

`ifdef SPI_MISO_TRISTATE_EN
    assign MISO = w_cs ? 1'bz : r_miso;
`else
    assign MISO = w_cs ? 1'b0 : r_miso;
`endif

    assign CS          = w_cs;
    assign TxGetNext   = r_tx_get_next;
    assign RxPacket    = r_rx_packet;
    assign PktComplete = r_pkt_complete;

endmodule

// File: doc/spi_frame_slave.md
# spi_frame_slave

SPI slave front end that serialises 128-bit trace frames onto MISO and deserialises 32-bit host command packets from MOSI. It sits directly downstream of the frame-to-SPI framer: it consumes `TxFrame` and produces that block's `TxGetNext`, `RxPacket`, `PktComplete` and `CS` inputs. All logic runs in the `clk` domain; the SPI pins are oversampled, so no SPI-clocked flops exist.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth on `SCK`, `MOSI` and `CS_N`; legal range 2–3.

Ports:
- `clk` input 1: system clock; must be ≥ 10× SCK.
- `rst` input 1: asynchronous, active-high reset; clock `clk`.
- `SCK` input 1: raw SPI clock, mode 0 (CPOL=0, CPHA=0).
- `MOSI` input 1: raw SPI data in, MSB first.
- `CS_N` input 1: raw chip select, active low.
- `MISO` output 1: SPI data out, MSB first.
- `TxFrame` input 128: next frame to transmit; framer holds it stable.
- `TxGetNext` output 1: toggles once per frame load, requesting the next frame.
- `RxPacket` output 32: last complete received packet.
- `PktComplete` output 1: toggles once per completed 32-bit packet.
- `CS` output 1: synchronised chip select, 1 = deselected.

## Operation

- Sync: `SCK`, `MOSI` and `CS_N` each pass through `SYNC_STAGES` flops. One extra flop on `SCK` gives rise/fall strobes `sck_r`/`sck_f`.
- `CS` = synchronised `CS_N`.
- FSM states:
  - IDLE: `CS`=1; counters held at 0.
  - LOAD: one cycle, entered on `CS` 1→0.
  - SHIFT: active transfer.
- IDLE→LOAD on `CS` falling.
- LOAD:
  - `tx_sr` ← `TxFrame`.
  - `MISO` ← `TxFrame[127]`.
  - `TxGetNext` toggles.
  - `bitcnt` ← 0.
  - Go to SHIFT.
- SHIFT, on `sck_r`:
  - `rx_sr` ← {`rx_sr[30:0]`, MOSI_sync}.
  - `bitcnt`++ (7-bit, wraps 127→0).
  - If `rx_sr` now holds 32 new bits (`bitcnt[4:0]`==31 before increment): `RxPacket` ← new value and `PktComplete` toggles, in the same cycle.
- SHIFT, on `sck_f`:
  - If `bitcnt`≠0: `tx_sr` shifts left and `MISO` ← next bit.
  - If `bitcnt`==0 after a wrap (128 bits done): reload `tx_sr` ← `TxFrame`, `MISO` ← `TxFrame[127]`, toggle `TxGetNext`.
- Any state, `CS` 0→1:
  - Go to IDLE.
  - Discard the partial rx packet and partial tx frame.
  - No toggles.
  - `RxPacket` keeps its last value.
- Priority when `CS` rises in the same cycle as an SCK strobe: the `CS` rise wins and the strobe is ignored.
- A `sck_f` with `bitcnt`==0 that is not after a wrap is ignored. This covers the first falling edge before any rise.
- Toggle outputs are level-encoded events. The consumer detects either edge.

## Timing

- Reset values:
  - `TxGetNext`=0, `PktComplete`=0, `RxPacket`=0.
  - `CS`=1.
  - `MISO`=0 (Z with `SPI_MISO_TRISTATE_EN`).
  - FSM = IDLE.
  - `bitcnt`=0.
  - Synchronisers = idle values (SCK 0, CS_N 1).
- Raw pin edge → strobe latency: `SYNC_STAGES`+1 clk.
- `CS_N` fall → `MISO` valid: `SYNC_STAGES`+2 clk. The master must wait ≥ that before its first SCK rise.
- SCK fall → `MISO` update: `SYNC_STAGES`+2 clk. Hence the clk ≥ 10× SCK requirement.
- 32nd SCK rise → `RxPacket`/`PktComplete`: `SYNC_STAGES`+2 clk, both in the same cycle.
- `TxGetNext` toggle → next reload: one full frame (128 SCK periods). The framer has that whole window to update `TxFrame`.
- Reset mid-transfer takes effect immediately (async) and gives reset values. The master must deassert `CS_N` before resuming.

## Configuration

- `SPI_MISO_TRISTATE_EN` defined: `MISO` = 1'bz whenever `CS`=1 (IDLE and reset), and driven only in LOAD/SHIFT. This allows multiple slaves to share the line.
- Not defined: `MISO` is always driven, and is 0 while `CS`=1.

## Structure

- Package `spi_frame_pkg`:
  - `FRAME_W`=128, `PKT_W`=32, `BITCNT_W`=7.
  - FSM state typedef: IDLE, LOAD, SHIFT.
- Sub-module `spi_pin_sync`:
  - Parameterised synchroniser for one pin.
  - Outputs synced level plus rise/fall strobes.
  - Instantiated three times.
- Top holds the FSM, shift registers, counters and toggle flops.

## Test plan

- `TxFrame`=128'hA600_..._FFFFFF7F, `CS_N` low, 128 SCK → host reads exactly that value MSB first. `TxGetNext` toggles once at the LOAD cycle and once after the 128th fall.
- Host sends 32'h0203_0010 on MOSI in the first frame → `RxPacket`=32'h02030010; `PktComplete` toggles exactly once per 32 bits (4 times per frame).
- Framer changes `TxFrame` to 128'h0123…CDEF within the frame after a `TxGetNext` toggle → the second frame reads 128'h0123…CDEF.
- `CS_N` raised after 45 bits → `CS`=1 and IDLE. `RxPacket` retains packet 1, with 1 `PktComplete` toggle total. The next `CS_N` fall restarts at bit 127 of the current `TxFrame`.
- `rst` pulsed mid-frame → all outputs at reset values the same cycle; after release and a new select, the transfer starts cleanly.
- `SPI_MISO_TRISTATE_EN` build: `MISO`=Z while `CS_N`=1 and driven during transfer. Non-macro build: `MISO`=0 while idle.
